// File: rtl/wb_arbiter_pkg.sv
// Shared types for the register-bank write-back path.
package wb_arbiter_pkg;

  localparam int WB_FIFO_DEPTH = 4;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO of pending late write-back entries; head is valid whenever !empty.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t din,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  wb_entry_t        mem_r [DEPTH];
  logic             push_s;
  logic             pop_s;

  assign full   = (count_r == CNT_W'(DEPTH));
  assign empty  = (count_r == {CNT_W{1'b0}});
  // Guard against overflow/underflow even if the caller misbehaves.
  assign push_s = push & ~full;
  assign pop_s  = pop & ~empty;
  assign head   = mem_r[rd_ptr_r];

  // Pointer and occupancy tracking; pointers wrap naturally at power-of-2 depth.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are only observed through a valid head.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= din;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-bank write port arbiter: pipeline results win, late results queue in a FIFO,
// and a busy scoreboard tracks registers with outstanding late writes.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pipe_we_i,
  input  logic [4:0]  pipe_rd_i,
  input  logic [31:0] pipe_data_i,
  input  logic        late_valid_i,
  output logic        late_ready_o,
  input  logic [4:0]  late_rd_i,
  input  logic [31:0] late_data_i,
  input  logic        alloc_i,
  input  logic [4:0]  alloc_rd_i,
  output logic [4:0]  rd_o,
  output logic        enable_o,
  output logic [31:0] data_o,
  output logic [31:0] busy_o
);

  wb_entry_t   push_entry_s;
  wb_entry_t   fifo_head_s;
  logic        fifo_full_s;
  logic        fifo_empty_s;
  logic        push_s;
  logic        pop_s;
  logic [31:0] set_mask_s;
  logic [31:0] clr_mask_s;
  logic [31:0] busy_nxt_s;
  logic [31:0] busy_r;

  // Ready comes only from registered occupancy, never from a same-cycle pop.
  assign late_ready_o      = ~fifo_full_s;
  // Late results to x0 complete the handshake but are never stored.
  assign push_s            = late_valid_i & late_ready_o & (late_rd_i != 5'd0);
  assign push_entry_s.rd   = late_rd_i;
  assign push_entry_s.data = late_data_i;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_s),
    .pop     (pop_s),
    .din     (push_entry_s),
    .head    (fifo_head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // Write-port select: pipeline first, FIFO head fills otherwise idle slots.
  always_comb begin
    rd_o     = 5'd0;
    data_o   = 32'd0;
    enable_o = 1'b0;
    pop_s    = 1'b0;
    if (pipe_we_i && (pipe_rd_i != 5'd0)) begin
      rd_o     = pipe_rd_i;
      data_o   = pipe_data_i;
      enable_o = 1'b1;
    end else if (!fifo_empty_s) begin
      rd_o     = fifo_head_s.rd;
      data_o   = fifo_head_s.data;
      enable_o = 1'b1;
      pop_s    = 1'b1;
    end else begin
      enable_o = 1'b0;
    end
  end

  // Set is applied after clear so a same-register alloc survives a pop; x0 is never busy.
  assign clr_mask_s = pop_s   ? (32'd1 << fifo_head_s.rd) : 32'd0;
  assign set_mask_s = alloc_i ? (32'd1 << alloc_rd_i)     : 32'd0;
  assign busy_nxt_s = ((busy_r & ~clr_mask_s) | set_mask_s) & 32'hFFFF_FFFE;
  assign busy_o     = busy_r;

  // Scoreboard register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_r <= 32'd0;
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter.
module tb_wb_arbiter;

  logic        clk;
  logic        reset_n;
  logic        pipe_we_i;
  logic [4:0]  pipe_rd_i;
  logic [31:0] pipe_data_i;
  logic        late_valid_i;
  logic        late_ready_o;
  logic [4:0]  late_rd_i;
  logic [31:0] late_data_i;
  logic        alloc_i;
  logic [4:0]  alloc_rd_i;
  logic [4:0]  rd_o;
  logic        enable_o;
  logic [31:0] data_o;
  logic [31:0] busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  wb_arbiter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pipe_we_i    (pipe_we_i),
    .pipe_rd_i    (pipe_rd_i),
    .pipe_data_i  (pipe_data_i),
    .late_valid_i (late_valid_i),
    .late_ready_o (late_ready_o),
    .late_rd_i    (late_rd_i),
    .late_data_i  (late_data_i),
    .alloc_i      (alloc_i),
    .alloc_rd_i   (alloc_rd_i),
    .rd_o         (rd_o),
    .enable_o     (enable_o),
    .data_o       (data_o),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] w5(input logic [4:0] v);
    return {27'd0, v};
  endfunction

  function automatic logic [31:0] w1(input logic v);
    return {31'd0, v};
  endfunction

  initial begin
    reset_n      = 1'b0;
    pipe_we_i    = 1'b0;
    pipe_rd_i    = 5'd0;
    pipe_data_i  = 32'd0;
    late_valid_i = 1'b0;
    late_rd_i    = 5'd0;
    late_data_i  = 32'd0;
    alloc_i      = 1'b0;
    alloc_rd_i   = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;

    // Reset state
    chk("rst_busy",  busy_o, 32'd0);
    chk("rst_en",    w1(enable_o), 32'd0);
    chk("rst_ready", w1(late_ready_o), 32'd1);
    chk("rst_rd",    w5(rd_o), 32'd0);
    chk("rst_data",  data_o, 32'd0);
    cyc();
    chk("rst_en_idle", w1(enable_o), 32'd0);

    // Pipe only
    pipe_we_i = 1'b1; pipe_rd_i = 5'd5; pipe_data_i = 32'hDEAD_BEEF;
    #1;
    chk("pipe_rd",   w5(rd_o), 32'd5);
    chk("pipe_en",   w1(enable_o), 32'd1);
    chk("pipe_data", data_o, 32'hDEAD_BEEF);
    cyc();
    pipe_we_i = 1'b0;

    // Priority: late x7 waits behind two pipeline writes to x3
    alloc_i = 1'b1; alloc_rd_i = 5'd7;
    cyc();
    alloc_i = 1'b0;
    pipe_we_i = 1'b1; pipe_rd_i = 5'd3; pipe_data_i = 32'hAAAA_0001;
    late_valid_i = 1'b1; late_rd_i = 5'd7; late_data_i = 32'h11;
    #1;
    chk("pri_ready", w1(late_ready_o), 32'd1);
    chk("pri_rd0",   w5(rd_o), 32'd3);
    chk("pri_data0", data_o, 32'hAAAA_0001);
    cyc();
    late_valid_i = 1'b0; pipe_data_i = 32'hBBBB_0002;
    #1;
    chk("pri_rd1",   w5(rd_o), 32'd3);
    chk("pri_data1", data_o, 32'hBBBB_0002);
    chk("pri_busy7", w1(busy_o[7]), 32'd1);
    cyc();
    pipe_we_i = 1'b0;
    #1;
    chk("pri_late_rd",   w5(rd_o), 32'd7);
    chk("pri_late_data", data_o, 32'h11);
    chk("pri_late_en",   w1(enable_o), 32'd1);
    chk("pri_busy7_pop", w1(busy_o[7]), 32'd1);
    cyc();
    chk("pri_idle_en", w1(enable_o), 32'd0);
    chk("pri_busy_clr", busy_o, 32'd0);

    // Full: four entries accepted while pipe holds the port, fifth refused
    pipe_we_i = 1'b1; pipe_rd_i = 5'd1; pipe_data_i = 32'd0;
    for (int i = 0; i < 4; i++) begin
      late_valid_i = 1'b1; late_rd_i = 5'(10 + i); late_data_i = 32'(100 + i);
      #1;
      chk("full_ready_fill", w1(late_ready_o), 32'd1);
      cyc();
    end
    late_rd_i = 5'd14; late_data_i = 32'd104;
    #1;
    chk("full_ready_5th", w1(late_ready_o), 32'd0);
    cyc();
    late_valid_i = 1'b0; pipe_we_i = 1'b0;
    #1;
    chk("full_ready_pop0", w1(late_ready_o), 32'd0);
    chk("drain_rd0",   w5(rd_o), 32'd10);
    chk("drain_data0", data_o, 32'd100);
    cyc();
    chk("full_ready_back", w1(late_ready_o), 32'd1);
    for (int i = 1; i < 4; i++) begin
      chk("drain_rd",   w5(rd_o), 32'(10 + i));
      chk("drain_data", data_o, 32'(100 + i));
      cyc();
    end
    chk("drain_done_en", w1(enable_o), 32'd0);

    // Scoreboard race and x0 handling
    alloc_i = 1'b1; alloc_rd_i = 5'd9;
    cyc();
    alloc_i = 1'b0;
    late_valid_i = 1'b1; late_rd_i = 5'd9; late_data_i = 32'd99;
    #1;
    chk("nobypass_en", w1(enable_o), 32'd0);
    cyc();
    late_valid_i = 1'b0;
    alloc_i = 1'b1; alloc_rd_i = 5'd9;
    #1;
    chk("race_rd",   w5(rd_o), 32'd9);
    chk("race_data", data_o, 32'd99);
    cyc();
    alloc_i = 1'b0;
    #1;
    chk("race_busy", busy_o, 32'h0000_0200);
    alloc_i = 1'b1; alloc_rd_i = 5'd0;
    cyc();
    alloc_i = 1'b0;
    #1;
    chk("alloc_x0_busy", busy_o, 32'h0000_0200);
    late_valid_i = 1'b1; late_rd_i = 5'd0; late_data_i = 32'd55;
    #1;
    chk("x0_ready", w1(late_ready_o), 32'd1);
    cyc();
    late_valid_i = 1'b0;
    #1;
    chk("x0_no_write0", w1(enable_o), 32'd0);
    cyc();
    chk("x0_no_write1", w1(enable_o), 32'd0);

    // Reset mid-operation with three queued entries
    alloc_i = 1'b1; alloc_rd_i = 5'd10;
    cyc();
    alloc_rd_i = 5'd11;
    cyc();
    alloc_i = 1'b0;
    pipe_we_i = 1'b1; pipe_rd_i = 5'd2; pipe_data_i = 32'd2;
    for (int i = 0; i < 3; i++) begin
      late_valid_i = 1'b1; late_rd_i = 5'(9 + i); late_data_i = 32'(900 + i);
      cyc();
    end
    late_valid_i = 1'b0;
    #1;
    chk("mid_busy",  busy_o, 32'h0000_0E00);
    chk("mid_ready", w1(late_ready_o), 32'd1);
    pipe_we_i = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy",  busy_o, 32'd0);
    chk("mid_rst_en",    w1(enable_o), 32'd0);
    chk("mid_rst_ready", w1(late_ready_o), 32'd1);
    cyc();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("post_rst_no_write", w1(enable_o), 32'd0);
      cyc();
    end
    late_valid_i = 1'b1; late_rd_i = 5'd20; late_data_i = 32'd2020;
    cyc();
    late_valid_i = 1'b0;
    #1;
    chk("post_rst_rd",   w5(rd_o), 32'd20);
    chk("post_rst_data", data_o, 32'd2020);
    cyc();
    chk("post_rst_idle", w1(enable_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
